// File: rtl/ram_copy_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_copy_pkg : shared FSM states, default widths and helpers for         |
// |                ram_copy_dma.                          Revision: 1.0      |
// +--------------------------------------------------------------------------+
package ram_copy_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = DEF_ADDR_W + 1;
  localparam int RAM_WORDS  = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A transfer never needs more words than the RAM holds.
  function automatic int unsigned sat_len(input int unsigned l);
    return (l > RAM_WORDS) ? RAM_WORDS : l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_copy_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_copy_ctr : loadable word-index counter with terminal-count flag and  |
// |                modulo source/destination address adders. Revision: 1.0   |
// +--------------------------------------------------------------------------+
module ram_copy_ctr
  import ram_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              last,
  output logic [ADDR_W-1:0] src_nx,
  output logic [ADDR_W-1:0] dst_nx
);

  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_nx;

  always_comb begin
    idx_nx = idx;
    if (load) begin
      idx_nx = '0;
    end else if (inc) begin
      idx_nx = idx + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else begin
      idx <= idx_nx;
    end
  end

  assign last = ((idx + LEN_W'(1)) == len);

  // Addresses are formed from the index of the coming cycle so the top level
  // can register them; the adders wrap naturally at 2^ADDR_W.
  assign src_nx = src_base + idx_nx[ADDR_W-1:0];
  assign dst_nx = dst_base + idx_nx[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/ram_copy_dma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_copy_dma : block-copy initiator on the CPU data RAM port; optional   |
// |                constant fill when RAM_COPY_FILL_EN is defined. Rev: 1.0  |
// +--------------------------------------------------------------------------+
module ram_copy_dma
  import ram_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              fill_en,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              m_wr_en,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] W_data,
  input  logic [DATA_W-1:0] R_data
);

  state_t            state;
  state_t            state_nx;
  logic              accept;
  logic              inc;
  logic              last;
  logic [LEN_W-1:0]  len_sat;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W-1:0] src_nx;
  logic [ADDR_W-1:0] dst_nx;
  logic              fill_mode;
  logic              fill_start;
  logic [DATA_W-1:0] fill_val;

  assign len_sat = LEN_W'(sat_len(32'(len)));

`ifdef RAM_COPY_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else if (accept) begin
      fill_q      <= fill_en;
      fill_data_q <= fill_data;
    end
  end

  assign fill_mode  = fill_q;
  assign fill_start = fill_en;
  assign fill_val   = accept ? fill_data : fill_data_q;
`else
  logic unused_fill;

  assign unused_fill = ^{fill_en, fill_data};
  assign fill_mode   = 1'b0;
  assign fill_start  = 1'b0;
  assign fill_val    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (accept) begin
      src_q <= src_addr;
      dst_q <= dst_addr;
      len_q <= len_sat;
    end
  end

  // Bases bypass the latches on the accept edge so the first address is ready.
  assign src_base = accept ? src_addr : src_q;
  assign dst_base = accept ? dst_addr : dst_q;

  ram_copy_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .inc      (inc),
    .len      (len_q),
    .src_base (src_base),
    .dst_base (dst_base),
    .last     (last),
    .src_nx   (src_nx),
    .dst_nx   (dst_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    inc      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (len_sat == '0) begin
            state_nx = DONE;
          end else if (fill_start) begin
            state_nx = WRITE;
          end else begin
            state_nx = READ;
          end
        end
      end
      READ: begin
        state_nx = WRITE;
      end
      WRITE: begin
        inc = 1'b1;
        if (last) begin
          state_nx = DONE;
        end else if (fill_mode) begin
          state_nx = WRITE;
        end else begin
          state_nx = READ;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state, so they hold steady for the
  // whole cycle and the RAM's negedge write sees settled address and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      m_wr_en <= 1'b0;
      Addr    <= '0;
      W_data  <= '0;
    end else begin
      busy    <= (state_nx == READ) || (state_nx == WRITE);
      done    <= (state_nx == DONE);
      m_wr_en <= (state_nx == WRITE);
      if (state_nx == READ) begin
        Addr <= src_nx;
      end else if (state_nx == WRITE) begin
        Addr <= dst_nx;
      end
      // W_data doubles as the data register: the read word is captured here.
      if (state_nx == WRITE) begin
        W_data <= (state == READ) ? R_data : fill_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_dma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_copy_dma : self-checking bench for ram_copy_dma with RAM model    |
// |                   and word-level reference copy model.  Revision: 1.0    |
// +--------------------------------------------------------------------------+
module tb_ram_copy_dma;

`ifdef RAM_COPY_FILL_EN
  localparam bit FILL_BUILT = 1'b1;
`else
  localparam bit FILL_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  src_addr;
  logic [8:0]  dst_addr;
  logic [9:0]  len;
  logic        fill_en;
  logic [15:0] fill_data;
  logic        busy;
  logic        done;
  logic        m_wr_en;
  logic [8:0]  Addr;
  logic [15:0] W_data;
  logic [15:0] R_data;

  logic [15:0] mem  [512];
  logic [15:0] img  [512];
  logic [15:0] refm [512];
  logic        load_req = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_copy_dma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_en   (fill_en),
    .fill_data (fill_data),
    .busy      (busy),
    .done      (done),
    .m_wr_en   (m_wr_en),
    .Addr      (Addr),
    .W_data    (W_data),
    .R_data    (R_data)
  );

  always @(negedge clk) begin
    if (load_req) mem <= img;
    else if (m_wr_en) mem[Addr] <= W_data;
  end
  assign R_data = mem[Addr];

  typedef struct {
    logic [8:0]        src;
    logic [8:0]        dst;
    logic [9:0]        len;
    logic              fe;
    logic [15:0]       fd;
    bit                poke;
    int                exp_busy;
    int                exp_done;
    int                exp_wr;
    int                chk_addr;
    int                chk_n;
    logic [3:0][15:0]  chk_val;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mkv(input int s, input int d, input int l, input int fe,
                               input int fd, input int poke, input int eb, input int ed,
                               input int ew, input int ca, input int cn,
                               input int v0, input int v1, input int v2, input int v3);
    vec_t v;
    v.src = 9'(s); v.dst = 9'(d); v.len = 10'(l); v.fe = fe[0]; v.fd = 16'(fd);
    v.poke = poke[0]; v.exp_busy = eb; v.exp_done = ed; v.exp_wr = ew;
    v.chk_addr = ca; v.chk_n = cn;
    v.chk_val[0] = 16'(v0); v.chk_val[1] = 16'(v1);
    v.chk_val[2] = 16'(v2); v.chk_val[3] = 16'(v3);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < 512; i++) begin
      img[i]  = rnd ? 16'($urandom) : 16'(10 * i);
      refm[i] = img[i];
    end
    load_req = 1'b1;
    @(negedge clk);
    #1 load_req = 1'b0;
  endtask

  // Reference: words move one by one in ascending order, modulo RAM size.
  task automatic apply_model(input int s, input int d, input int l, input bit fill,
                             input logic [15:0] fd);
    int n;
    n = (l > 512) ? 512 : l;
    for (int i = 0; i < n; i++)
      refm[(d + i) % 512] = fill ? fd : refm[(s + i) % 512];
  endtask

  task automatic cmp_mem(input string tag);
    int nd;
    int first;
    nd = 0;
    first = -1;
    for (int i = 0; i < 512; i++) begin
      if (mem[i] !== refm[i]) begin
        nd++;
        if (first < 0) first = i;
      end
    end
    n_cmp++;
    if (nd != 0) begin
      n_bad++;
      $display("FAIL %s_mem: %0d words differ, first at %0d actual=%0h required=%0h",
               tag, nd, first, mem[first], refm[first]);
    end
  endtask

  task automatic run_xfer(input logic [8:0] s, input logic [8:0] d, input logic [9:0] l,
                          input logic fe, input logic [15:0] fd, input bit poke,
                          output int bcnt, output int wcnt, output int done_k,
                          output int dcnt);
    bcnt = 0; wcnt = 0; done_k = 0; dcnt = 0;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = l; fill_en = fe; fill_data = fd;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_addr = 9'($urandom); dst_addr = 9'($urandom); len = 10'($urandom);
    fill_en = 1'($urandom); fill_data = 16'($urandom);
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (m_wr_en) wcnt++;
      if (done) begin
        dcnt++;
        if (done_k == 0) done_k = k;
      end
      if (poke && k == 3) begin
        start = 1'b1; src_addr = 9'd0; dst_addr = 9'd400; len = 10'd2;
      end else begin
        start = 1'b0;
      end
      if (done_k != 0 && k == done_k + 1) break;
    end
  endtask

  initial begin
    int  bc, wc, dk, dc, n;
    bit  fm;
    logic [8:0]  s, d;
    logic [9:0]  l;
    logic        fe;
    logic [15:0] fd;

    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    fill_en = 1'b0; fill_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", m_wr_en, 0);
    chk("rst_addr", Addr, 0);
    chk("rst_wdata", W_data, 0);
    rst_n = 1'b1;

    tbl[0] = mkv(0, 100, 4, 0, 0, 0, 8, 9, 4, 100, 4, 0, 10, 20, 30);
    tbl[1] = mkv(510, 20, 4, 0, 0, 0, 8, 9, 4, 20, 4, 5100, 5110, 0, 10);
    tbl[2] = mkv(0, 1, 3, 0, 0, 0, 6, 7, 3, 0, 4, 0, 0, 0, 0);
    tbl[3] = mkv(5, 7, 0, 0, 0, 0, 0, 1, 0, 7, 1, 70, 0, 0, 0);
`ifdef RAM_COPY_FILL_EN
    tbl[4] = mkv(50, 300, 3, 1, 'hBEEF, 0, 3, 4, 3, 300, 3, 'hBEEF, 'hBEEF, 'hBEEF, 0);
`else
    tbl[4] = mkv(50, 300, 3, 1, 'hBEEF, 0, 6, 7, 3, 300, 3, 500, 510, 520, 0);
`endif
    tbl[5] = mkv(0, 256, 1000, 0, 0, 0, 1024, 1025, 512, 256, 4, 0, 10, 20, 30);
    tbl[6] = mkv(40, 60, 4, 0, 0, 1, 8, 9, 4, 60, 4, 400, 410, 420, 430);

    for (int r = 0; r < 7; r++) begin
      preload(1'b0);
      apply_model(int'(tbl[r].src), int'(tbl[r].dst), int'(tbl[r].len),
                  tbl[r].fe && FILL_BUILT, tbl[r].fd);
      run_xfer(tbl[r].src, tbl[r].dst, tbl[r].len, tbl[r].fe, tbl[r].fd, tbl[r].poke,
               bc, wc, dk, dc);
      chk($sformatf("row%0d_busy_cycles", r), bc, tbl[r].exp_busy);
      chk($sformatf("row%0d_done_cycle", r), dk, tbl[r].exp_done);
      chk($sformatf("row%0d_done_pulses", r), dc, 1);
      chk($sformatf("row%0d_writes", r), wc, tbl[r].exp_wr);
      cmp_mem($sformatf("row%0d", r));
      for (int j = 0; j < tbl[r].chk_n; j++)
        chk($sformatf("row%0d_word%0d", r, j), mem[(tbl[r].chk_addr + j) % 512],
            tbl[r].chk_val[j]);
    end

    for (int t = 0; t < 10; t++) begin
      preload(1'b1);
      s = 9'($urandom); d = 9'($urandom); l = 10'($urandom_range(0, 20));
      fe = 1'($urandom); fd = 16'($urandom);
      fm = fe && FILL_BUILT;
      n = int'(l);
      apply_model(int'(s), int'(d), n, fm, fd);
      run_xfer(s, d, l, fe, fd, 1'b0, bc, wc, dk, dc);
      chk($sformatf("rnd%0d_busy_cycles", t), bc, (n == 0) ? 0 : (fm ? n : 2 * n));
      chk($sformatf("rnd%0d_done_cycle", t), dk, (n == 0) ? 1 : (fm ? n + 1 : 2 * n + 1));
      chk($sformatf("rnd%0d_done_pulses", t), dc, 1);
      chk($sformatf("rnd%0d_writes", t), wc, n);
      cmp_mem($sformatf("rnd%0d", t));
    end

    // Reset during the third write of a five-word copy.
    preload(1'b0);
    apply_model(0, 200, 2, 1'b0, 16'h0);
    @(negedge clk);
    start = 1'b1; src_addr = 9'd0; dst_addr = 9'd200; len = 10'd5; fill_en = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_wr_en_before", m_wr_en, 1);
    chk("abort_addr_before", Addr, 202);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_en", m_wr_en, 0);
    chk("abort_addr", Addr, 0);
    chk("abort_wdata", W_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", done, 0);
    chk("abort_word200", mem[200], 0);
    chk("abort_word201", mem[201], 10);
    chk("abort_word202", mem[202], 2020);
    chk("abort_word204", mem[204], 2040);
    cmp_mem("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
